// File: rtl/demux1_2_2bits_fifo.sv
// Receive side of the 2-bit 2:1 mux path: steers each accepted word into one of two
// show-ahead FIFO lanes with valid/pop outputs and a per-lane transfer counter.
module demux1_2_2bits_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 7,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             selector,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic             valid_out0,
    input  logic             pop0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out1,
    input  logic             pop1,
    output logic [LVL_W-1:0] level0,
    output logic [LVL_W-1:0] level1,
    output logic [CNT_W-1:0] xfer_count0,
    output logic [CNT_W-1:0] xfer_count1
);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [LVL_W-1:0] level_q  [2];
    logic [LVL_W-1:0] level_d  [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];

    logic [1:0] full;
    logic [1:0] not_empty;
    logic [1:0] push;
    logic [1:0] pop;

    assign full[0]      = (level_q[0] == LVL_W'(DEPTH));
    assign full[1]      = (level_q[1] == LVL_W'(DEPTH));
    assign not_empty[0] = (level_q[0] != '0);
    assign not_empty[1] = (level_q[1] != '0);

    // Back-pressure depends only on the addressed lane's registered level, never on pops.
    assign ready_in = ~full[selector];
    assign push     = {valid_in & ready_in & selector, valid_in & ready_in & ~selector};
    assign pop      = {pop1 & not_empty[1], pop0 & not_empty[0]};

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(push[l]);
            rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(pop[l]);
            level_d[l]  = level_q[l] + LVL_W'(push[l]) - LVL_W'(pop[l]);
            cnt_d[l]    = cnt_q[l] + CNT_W'(push[l]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                level_q[l]  <= '0;
                cnt_q[l]    <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                level_q[l]  <= level_d[l];
                cnt_q[l]    <= cnt_d[l];
            end
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are invisible because
    // the outputs are masked whenever a lane is empty.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                mem_q[l][wr_ptr_q[l]] <= data_in;
            end
        end
    end

    assign valid_out0  = not_empty[0];
    assign valid_out1  = not_empty[1];
    assign data_out0   = not_empty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign data_out1   = not_empty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    assign level0      = level_q[0];
    assign level1      = level_q[1];
    assign xfer_count0 = cnt_q[0];
    assign xfer_count1 = cnt_q[1];

endmodule

// File: tb/tb_demux1_2_2bits_fifo.sv
// Directed bench for demux1_2_2bits_fifo: a vector table for routing, stall and
// pop behaviour, then hand-written async-reset and counter-wrap sequences.
module tb_demux1_2_2bits_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] data_in;
    logic       valid_in;
    logic       selector;
    logic       ready_in;
    logic [1:0] data_out0;
    logic       valid_out0;
    logic       pop0;
    logic [1:0] data_out1;
    logic       valid_out1;
    logic       pop1;
    logic [1:0] level0;
    logic [1:0] level1;
    logic [6:0] xfer_count0;
    logic [6:0] xfer_count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux1_2_2bits_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .selector    (selector),
        .ready_in    (ready_in),
        .data_out0   (data_out0),
        .valid_out0  (valid_out0),
        .pop0        (pop0),
        .data_out1   (data_out1),
        .valid_out1  (valid_out1),
        .pop1        (pop1),
        .level0      (level0),
        .level1      (level1),
        .xfer_count0 (xfer_count0),
        .xfer_count1 (xfer_count1)
    );

    typedef struct packed {
        logic [1:0] d;
        logic       v;
        logic       s;
        logic       p0;
        logic       p1;
        logic       rdy;
        logic [1:0] d0;
        logic       v0;
        logic [1:0] d1;
        logic       v1;
        logic [1:0] l0;
        logic [1:0] l1;
        logic [6:0] c0;
        logic [6:0] c1;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic v, input logic s,
                         input logic p0, input logic p1);
        data_in  = d;
        valid_in = v;
        selector = s;
        pop0     = p0;
        pop1     = p1;
    endtask

    logic [1:0] model_q[$];
    int         accepted;
    int         cycles;
    logic [1:0] word;

    initial begin
        //        d      v     s     p0    p1    rdy   d0     v0    d1     v1    l0    l1    c0    c1
        vecs[0]  = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 2'd1, 2'd0, 7'd1, 7'd0};
        vecs[1]  = {2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 2'd1, 2'd1, 7'd1, 7'd1};
        vecs[2]  = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 7'd1, 7'd1};
        vecs[3]  = {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 2'd1, 2'd0, 7'd2, 7'd1};
        vecs[4]  = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd3, 7'd1};
        vecs[5]  = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd3, 7'd1};
        vecs[6]  = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd3, 7'd1};
        vecs[7]  = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd3, 7'd1};
        vecs[8]  = {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd3, 7'd1};
        vecs[9]  = {2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 2'd1, 2'd0, 7'd3, 7'd1};
        vecs[10] = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 2'd2, 2'd0, 7'd4, 7'd1};
        vecs[11] = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 2'd1, 2'd0, 7'd4, 7'd1};
        vecs[12] = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 7'd4, 7'd1};
        vecs[13] = {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 7'd4, 7'd1};
        vecs[14] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 2'd0, 2'd1, 7'd4, 7'd2};
        vecs[15] = {2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 2'd0, 2'd1, 7'd4, 7'd3};
        vecs[16] = {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 7'd4, 7'd3};

        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_level0", 32'(level0), 0);
        check("rst_valid_out0", 32'(valid_out0), 0);
        check("rst_data_out1", 32'(data_out1), 0);
        check("rst_count1", 32'(xfer_count1), 0);
        check("rst_ready", 32'(ready_in), 1);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].p0, vecs[i].p1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", i),  32'(ready_in),    32'(vecs[i].rdy));
            check($sformatf("v%0d_data0", i),  32'(data_out0),   32'(vecs[i].d0));
            check($sformatf("v%0d_valid0", i), 32'(valid_out0),  32'(vecs[i].v0));
            check($sformatf("v%0d_data1", i),  32'(data_out1),   32'(vecs[i].d1));
            check($sformatf("v%0d_valid1", i), 32'(valid_out1),  32'(vecs[i].v1));
            check($sformatf("v%0d_level0", i), 32'(level0),      32'(vecs[i].l0));
            check($sformatf("v%0d_level1", i), 32'(level1),      32'(vecs[i].l1));
            check($sformatf("v%0d_count0", i), 32'(xfer_count0), 32'(vecs[i].c0));
            check($sformatf("v%0d_count1", i), 32'(xfer_count1), 32'(vecs[i].c1));
        end

        // Asynchronous reset in the middle of a cycle with lane0 full and a stalled sender.
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_level0", 32'(level0), 2);
        check("pre_rst_count0", 32'(xfer_count0), 6);
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_level0", 32'(level0), 0);
        check("async_rst_valid0", 32'(valid_out0), 0);
        check("async_rst_data0", 32'(data_out0), 0);
        check("async_rst_count0", 32'(xfer_count0), 0);
        check("async_rst_count1", 32'(xfer_count1), 0);
        check("async_rst_ready", 32'(ready_in), 1);
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Counter wrap: 130 accepted words into lane0, each popped as it reaches the head.
        accepted = 0;
        cycles   = 0;
        while (accepted < 130 && cycles < 400) begin
            word = 2'((accepted * 3 + 1) % 4);
            drive(word, 1'b1, 1'b0, valid_out0, 1'b0);
            #1;
            if (valid_out0) begin
                if (model_q.size() == 0) begin
                    check("stream0_unexpected_word", 32'(data_out0), 32'hDEAD);
                end else begin
                    total++;
                    if (data_out0 !== model_q[0]) begin
                        bad++;
                        $display("FAIL stream0 ERROR: got %0d expected %0d", data_out0, model_q[0]);
                    end
                    void'(model_q.pop_front());
                end
            end
            if (ready_in) begin
                model_q.push_back(word);
                accepted++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check("wrap_budget", 32'(accepted), 130);

        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles = 0;
        while (model_q.size() != 0 && cycles < 10) begin
            check("drain_valid0", 32'(valid_out0), 1);
            check("drain_data0", 32'(data_out0), 32'(model_q[0]));
            void'(model_q.pop_front());
            pop0 = 1'b1;
            @(posedge clk);
            #1;
            pop0 = 1'b0;
            cycles++;
        end
        check("wrap_count0", 32'(xfer_count0), 2);
        check("wrap_level0", 32'(level0), 0);
        check("wrap_valid0", 32'(valid_out0), 0);
        check("wrap_count1", 32'(xfer_count1), 0);
        check("wrap_level1", 32'(level1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
